vga_scanout_scheduler: RTL and testbench
========================================

// Module: vga_scanout_scheduler
// PURPOSE
//  Scanout fetch scheduler that sits beside vga_interval, driven by its hblank/vblank/py outputs.
//  - Sequences burst reads from framebuffer memory into a ping-pong line buffer, one line ahead of the beam.
//  - Lines 0/1 are prefetched during vblank. Each later line is fetched during the preceding line's hblank + active time.
//  - Reports which bank the pixel path reads, and flags underruns.
// PARAMETERS
//  H_ACTIVE        640    visible pixels per line
//  V_ACTIVE        480    visible lines per frame
//  DATA_W          32     memory data width, bits
//  ADDR_W          32     memory byte-address width
//  WORDS_PER_LINE  160    DATA_W words per line (640 px @ 8 bpp)
//  BURST_LEN       16     beats per read burst; must divide WORDS_PER_LINE
//  LINE_STRIDE     640    bytes between consecutive framebuffer lines
// PORTS
//  aclk        in   1       system clock
//  aresetn     in   1       async active-low reset
//  enable      in   1       allow new line fetches
//  fb_base     in   ADDR_W  framebuffer byte base; latched at vblank rise
//  hblank      in   1       from vga_interval
//  vblank      in   1       from vga_interval
//  py          in   12      current line, from vga_interval
//  rd_valid    out  1       burst read request valid
//  rd_ready    in   1       request accepted when rd_valid & rd_ready
//  rd_addr     out  ADDR_W  burst start byte address
//  rdata_valid in   1       read beat valid (no backpressure, in-order)
//  rdata       in   DATA_W  read beat data
//  lb_we       out  1       line-buffer write enable
//  lb_bank     out  1       bank being written
//  lb_waddr    out  8       word index within line, 0..WORDS_PER_LINE-1
//  lb_wdata    out  DATA_W  registered copy of rdata
//  disp_bank   out  1       bank the pixel path reads for the current line
//  busy        out  1       fetch in progress
//  underrun    out  1       sticky; cleared at vblank rise
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters 0; latched base 0. Async assert, sync release.
//  Edge detect:
//   - hblank/vblank registered once; rise = cur & ~prev.
//   - After reset, prev = current input, so no spurious edge fires.
//  Frame:
//   - vblank rise: latch fb_base, clear underrun, disp_bank<=0.
//   - If enable, queue line 0 -> bank 0, then line 1 -> bank 1, back-to-back.
//  Line: hblank rise with vblank=0 and py<V_ACTIVE (line y just finished):
//   - disp_bank <= ~disp_bank.
//   - If y+2<V_ACTIVE and enable, fetch line y+2 into bank y[0].
//   - The last two lines trigger no fetch.
//  FSM:
//   - IDLE -> REQ on trigger.
//   - REQ: rd_valid=1, rd_addr = base + line*LINE_STRIDE + burst*BURST_LEN*(DATA_W/8), held stable until accepted; on accept -> DATA.
//   - DATA: count BURST_LEN beats. Each beat -> lb_we=1 one cycle later, lb_waddr increments from burst*BURST_LEN.
//   - After the last beat: REQ for the next burst, IDLE when line complete, or REQ for a queued line.
//  Latency: rdata beat to lb_we is 1 cycle. busy=1 in every state except IDLE.
//  Underrun: new trigger while busy:
//   - underrun<=1.
//   - Current line is abandoned. From REQ, if rd_valid is not yet accepted, drop it the next cycle (protocol exception; memory side tolerates withdrawal).
//   - From DATA, go to DRAIN: swallow remaining beats with lb_we=0, then start the new line.
//   - A pending vblank prefetch queue is flushed by a line trigger and vice versa. The newest trigger wins.
//  Simultaneous trigger + last beat: the last beat is written, no underrun, new line starts next cycle.
//  enable=0: the in-flight line completes; no new triggers accepted.
//  Arithmetic: addresses wrap modulo 2**ADDR_W; py compare is unsigned 12-bit.
//  Reset mid-burst: state lost; the memory side must be reset with the same aresetn.
// STRUCTURE
//  Package vga_pkg: fetch_state_t enum {IDLE,REQ,DATA,DRAIN}; shared H/V_ACTIVE constants with vga_interval.
//  Sub-module vga_edge_detect (registered rise detector, reused for hblank and vblank).
//  FSM, beat counter, burst counter and address generator stay in this module.
// TESTING
//  Reset with hblank=1 held -> no rd_valid after release; all outputs 0.
//  vblank rise, fb_base=0x1000, rd_ready=1, zero-latency memory -> 20 bursts:
//   - First 10 bursts at 0x1000, 0x1040.. write bank 0; next 10 at 0x1280.. write bank 1.
//   - lb_waddr 0..159 each.
//  py=5 hblank rise, disp_bank=1 -> disp_bank=0; fetch at base+7*640 into bank 1.
//  rd_ready low 7 cycles -> rd_valid and rd_addr stable throughout; no beats lost.
//  Second hblank rise mid-DATA at beat 9 of 16 -> underrun=1; 7 beats dropped with lb_we=0; new line begins at its burst 0.
//  py=478 and py=479 hblank rises -> no rd_valid. fb_base changed mid-frame -> takes effect only after the next vblank rise.

Source files
------------

// File: rtl/vga_scanout_scheduler_pkg.sv
// Shared scanout definitions: fetch FSM states and the active-area geometry
// common to vga_interval and the scanout scheduler.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/vga_edge_detect.sv
// Registered rising-edge detector. The first cycle after reset only primes the
// history register, so a level already high at release never reports an edge.
module vga_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev;
  logic primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= 1'b0;
      primed <= 1'b0;
    end else begin
      prev   <= din;
      primed <= 1'b1;
    end
  end

  assign rise = primed & din & ~prev;

endmodule

// File: rtl/vga_scanout_scheduler.sv
// Fetches framebuffer lines into a ping-pong line buffer one line ahead of the
// beam: lines 0/1 during vblank, line y+2 when line y finishes.
module vga_scanout_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE       = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE       = VGA_V_ACTIVE,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 160,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned LINE_STRIDE    = 640
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [11:0]       py,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rdata_valid,
  input  logic [DATA_W-1:0] rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [7:0]        lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              disp_bank,
  output logic              busy,
  output logic              underrun
);

  localparam int unsigned BURSTS  = WORDS_PER_LINE / BURST_LEN;
  localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned BURST_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;

  if ((WORDS_PER_LINE % BURST_LEN) != 0 ||
      WORDS_PER_LINE * (DATA_W / 8) != H_ACTIVE) begin : g_cfg_err
    $error("vga_scanout_scheduler: line geometry does not match burst/pixel sizing");
  end

  fetch_state_t         state, state_d;
  logic [11:0]          line_q, line_d;
  logic                 bank_q, bank_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 qv_q, qv_d;
  logic [ADDR_W-1:0]    base_q;
  logic                 wr_beat;

  logic hrise, vrise;
  logic last_beat, last_burst, line_done, clean_handoff;
  logic line_evt, line_trig, frame_trig, trig, overrun;
  logic [11:0] trig_line;
  logic        trig_bank;

  vga_edge_detect u_hedge (.clk(aclk), .rst_n(aresetn), .din(hblank), .rise(hrise));
  vga_edge_detect u_vedge (.clk(aclk), .rst_n(aresetn), .din(vblank), .rise(vrise));

  assign last_beat     = rdata_valid && (beat_q == BEAT_W'(BURST_LEN - 1));
  assign last_burst    = (burst_q == BURST_W'(BURSTS - 1));
  assign line_done     = (state == DATA) && last_beat && last_burst;
  // A trigger landing on the final beat of a line with nothing queued is a
  // normal handoff, not an underrun.
  assign clean_handoff = line_done && !qv_q;

  assign frame_trig = vrise & enable;
  assign line_evt   = hrise & ~vblank & (py < 12'(V_ACTIVE));
  assign line_trig  = line_evt & enable & (py < 12'(V_ACTIVE - 2));
  assign trig       = frame_trig | line_trig;
  assign trig_line  = frame_trig ? 12'd0 : py + 12'd2;
  assign trig_bank  = frame_trig ? 1'b0 : py[0];
  assign overrun    = trig && (state != IDLE) && !clean_handoff;

  always_comb begin
    state_d = state;
    line_d  = line_q;
    bank_d  = bank_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    qv_d    = qv_q;
    wr_beat = 1'b0;
    unique case (state)
      IDLE: ;
      REQ: begin
        if (rd_ready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (rdata_valid) begin
          wr_beat = !trig || clean_handoff;
          beat_d  = beat_q + BEAT_W'(1);
          if (last_beat) begin
            beat_d = '0;
            if (!last_burst) begin
              burst_d = burst_q + BURST_W'(1);
              state_d = REQ;
            end else if (qv_q) begin
              line_d  = 12'd1;
              bank_d  = 1'b1;
              burst_d = '0;
              qv_d    = 1'b0;
              state_d = REQ;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DRAIN: begin
        if (rdata_valid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            beat_d  = '0;
            state_d = REQ;
          end
        end
      end
    endcase

    // Newest trigger replaces the current job and any queued prefetch; an
    // accepted burst still has to be drained before the new request goes out.
    if (trig) begin
      line_d  = trig_line;
      bank_d  = trig_bank;
      burst_d = '0;
      qv_d    = frame_trig;
      unique case (state)
        IDLE:  state_d = REQ;
        REQ: begin
          state_d = rd_ready ? DRAIN : REQ;
          beat_d  = '0;
        end
        DATA:  state_d = (rdata_valid && last_beat) ? REQ : DRAIN;
        DRAIN: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      line_q    <= '0;
      bank_q    <= 1'b0;
      burst_q   <= '0;
      beat_q    <= '0;
      qv_q      <= 1'b0;
      base_q    <= '0;
      disp_bank <= 1'b0;
      underrun  <= 1'b0;
      lb_we     <= 1'b0;
      lb_bank   <= 1'b0;
      lb_waddr  <= '0;
      lb_wdata  <= '0;
    end else begin
      state   <= state_d;
      line_q  <= line_d;
      bank_q  <= bank_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      qv_q    <= qv_d;

      if (vrise) begin
        base_q    <= fb_base;
        disp_bank <= 1'b0;
      end else if (line_evt) begin
        disp_bank <= ~disp_bank;
      end

      if (overrun)    underrun <= 1'b1;
      else if (vrise) underrun <= 1'b0;

      lb_we    <= wr_beat;
      lb_wdata <= rdata;
      if (state == DATA && rdata_valid) begin
        lb_bank  <= bank_q;
        lb_waddr <= 8'(burst_q) * 8'(BURST_LEN) + 8'(beat_q);
      end
    end
  end

  assign rd_valid = (state == REQ);
  assign busy     = (state != IDLE);
  assign rd_addr  = base_q
                  + ADDR_W'(line_q) * ADDR_W'(LINE_STRIDE)
                  + ADDR_W'(burst_q) * ADDR_W'(BURST_LEN * (DATA_W / 8));

endmodule

// File: tb/tb_vga_scanout_scheduler.sv
// Self-checking bench: randomized memory latency/stalls and framebuffer bases,
// checked against a line-level model of which words land in which bank.
module tb_vga_scanout_scheduler;

  localparam int unsigned WPL    = 160;
  localparam int unsigned BL     = 16;
  localparam int unsigned STRIDE = 640;

  logic        aclk = 1'b0;
  logic        aresetn, enable, hblank, vblank;
  logic [31:0] fb_base;
  logic [11:0] py;
  logic        rd_valid, rd_ready, rdata_valid;
  logic [31:0] rd_addr, rdata, lb_wdata;
  logic        lb_we, lb_bank, disp_bank, busy, underrun;
  logic [7:0]  lb_waddr;

  always #5 aclk = ~aclk;

  vga_scanout_scheduler #(
    .H_ACTIVE(640), .V_ACTIVE(480), .DATA_W(32), .ADDR_W(32),
    .WORDS_PER_LINE(WPL), .BURST_LEN(BL), .LINE_STRIDE(STRIDE)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .fb_base(fb_base),
    .hblank(hblank), .vblank(vblank), .py(py),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .disp_bank(disp_bank), .busy(busy), .underrun(underrun)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Memory model and logs
  logic [31:0] beat_q[$];
  logic [31:0] req_log[$], exp_req[$];
  logic [40:0] wr_log[$], exp_wr[$];
  int unsigned stall_cycles = 0;
  int unsigned beats_sent   = 0;
  bit          gaps         = 1'b0;
  bit          stalling     = 1'b0;
  logic [31:0] stall_addr;

  always @(negedge aclk) begin
    if (!aresetn) begin
      rd_ready    = 1'b0;
      rdata_valid = 1'b0;
      rdata       = '0;
      stalling    = 1'b0;
      beat_q.delete();
    end else begin
      if (beat_q.size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
        rdata_valid = 1'b1;
        rdata       = beat_q.pop_front();
        beats_sent++;
      end else begin
        rdata_valid = 1'b0;
        rdata       = $urandom;
      end
      rd_ready = 1'b0;
      if (stall_cycles > 0 && (rd_valid || stalling)) begin
        if (!stalling) begin
          stalling   = 1'b1;
          stall_addr = rd_addr;
        end else begin
          check("stall_rd_valid", rd_valid, 1'b1);
          check("stall_rd_addr", rd_addr, stall_addr);
        end
        stall_cycles--;
      end else if (rd_valid) begin
        stalling = 1'b0;
        rd_ready = 1'b1;
        req_log.push_back(rd_addr);
        for (int unsigned i = 0; i < BL; i++) beat_q.push_back(mem_word(rd_addr + 32'(4 * i)));
      end
    end
  end

  always @(negedge aclk) begin
    if (aresetn && lb_we) wr_log.push_back({lb_bank, lb_waddr, lb_wdata});
  end

  // Line-level reference: a fetch of line L into bank b issues one request per
  // burst and writes word w of the line to (b, w).
  logic [31:0] base_m;
  logic        disp_m;

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(negedge aclk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] base, input int unsigned line,
                           input logic bank, input int unsigned nwords);
    logic [31:0] la;
    la = base + 32'(line * STRIDE);
    for (int unsigned k = 0; k * BL < nwords; k++) exp_req.push_back(la + 32'(k * BL * 4));
    for (int unsigned w = 0; w < nwords; w++)
      exp_wr.push_back({bank, 8'(w), mem_word(la + 32'(4 * w))});
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    tick(3);
    while ((busy || beat_q.size() > 0 || lb_we) && n < 5000) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 1'b0);
    tick(2);
  endtask

  task automatic cmp_logs(input string tag);
    int unsigned f0;
    check({tag, "_nreq"}, req_log.size(), exp_req.size());
    f0 = n_fail;
    for (int unsigned i = 0; i < req_log.size() && i < exp_req.size() && n_fail == f0; i++)
      check({tag, "_req"}, req_log[i], exp_req[i]);
    check({tag, "_nwr"}, wr_log.size(), exp_wr.size());
    f0 = n_fail;
    for (int unsigned i = 0; i < wr_log.size() && i < exp_wr.size() && n_fail == f0; i++)
      check({tag, "_wr"}, wr_log[i], exp_wr[i]);
    req_log.delete(); exp_req.delete(); wr_log.delete(); exp_wr.delete();
  endtask

  task automatic line_pulse(input logic [11:0] y);
    py     = y;
    hblank = 1'b1;
    if (y < 12'd480) disp_m = ~disp_m;
    tick();
    hblank = 1'b0;
    tick();
  endtask

  task automatic frame(input logic [31:0] base, input string tag);
    fb_base = base;
    base_m  = base;
    disp_m  = 1'b0;
    vblank  = 1'b1;
    tick();
    push_line(base_m, 0, 1'b0, WPL);
    push_line(base_m, 1, 1'b1, WPL);
    wait_idle(tag);
    cmp_logs(tag);
    check({tag, "_disp"}, disp_bank, disp_m);
    check({tag, "_underrun"}, underrun, 1'b0);
    vblank = 1'b0;
    tick();
  endtask

  // Trigger the next line exactly when beat `nth` (0-based) of the current
  // line is on the bus.
  task automatic trigger_at_beat(input int unsigned b0, input int unsigned nth,
                                 input logic [11:0] y, input string tag);
    int unsigned n;
    n = 0;
    while (!(beats_sent == b0 + nth + 1 && rdata_valid) && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_beat_wait"}, beats_sent, b0 + nth + 1);
    line_pulse(y);
  endtask

  initial begin
    int unsigned b0;
    logic [11:0] y;

    aresetn = 1'b0; enable = 1'b0; hblank = 1'b1; vblank = 1'b0;
    py = '0; fb_base = '0; disp_m = 1'b0; base_m = '0;
    tick(3);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_addr", rd_addr, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_lb", {lb_we, lb_bank, lb_waddr, lb_wdata}, 42'h0);
    check("rst_disp_under", {disp_bank, underrun}, 2'b00);

    aresetn = 1'b1;
    enable  = 1'b1;
    repeat (8) begin
      tick();
      check("post_rst_rd_valid", rd_valid, 1'b0);
    end
    hblank = 1'b0;
    tick(2);

    frame(32'h0000_1000, "frame0");

    fb_base = 32'hDEAD_0000;
    line_pulse(12'd4);
    push_line(base_m, 6, 1'b0, WPL);
    wait_idle("py4");
    cmp_logs("py4");
    check("py4_disp", disp_bank, disp_m);

    stall_cycles = 7;
    line_pulse(12'd5);
    push_line(base_m, 7, 1'b1, WPL);
    wait_idle("py5_stall");
    cmp_logs("py5_stall");
    check("py5_disp", disp_bank, 1'b0);

    b0 = beats_sent;
    line_pulse(12'd10);
    push_line(base_m, 12, 1'b0, 2 * BL + 9);
    trigger_at_beat(b0, 2 * BL + 9, 12'd11, "under");
    push_line(base_m, 13, 1'b1, WPL);
    wait_idle("under");
    cmp_logs("under");
    check("under_flag", underrun, 1'b1);
    check("under_disp", disp_bank, disp_m);

    for (int unsigned i = 0; i < 2; i++) begin
      line_pulse(12'd478 + 12'(i));
      repeat (6) begin
        tick();
        check("last_lines_rd_valid", rd_valid, 1'b0);
      end
    end
    check("last_lines_disp", disp_bank, disp_m);
    check("last_lines_nreq", req_log.size(), 0);

    enable = 1'b0;
    line_pulse(12'd20);
    repeat (6) begin
      tick();
      check("disabled_rd_valid", rd_valid, 1'b0);
    end
    enable = 1'b1;

    frame(32'hFFFF_FC00, "frame_wrap");

    b0 = beats_sent;
    line_pulse(12'd30);
    push_line(base_m, 32, 1'b0, WPL);
    trigger_at_beat(b0, WPL - 1, 12'd31, "handoff");
    push_line(base_m, 33, 1'b1, WPL);
    wait_idle("handoff");
    cmp_logs("handoff");
    check("handoff_underrun", underrun, 1'b0);

    gaps = 1'b1;
    frame($urandom, "frame_rand");
    for (int unsigned it = 0; it < 6; it++) begin
      y = 12'($urandom_range(477, 0));
      stall_cycles = $urandom_range(5, 0);
      line_pulse(y);
      push_line(base_m, 32'(y) + 2, y[0], WPL);
      wait_idle("rand_line");
      cmp_logs("rand_line");
      check("rand_disp", disp_bank, disp_m);
      check("rand_underrun", underrun, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_tests);
    $fatal(1);
  end

endmodule
